// File: rtl/sys_array_sequencer.sv
// Job-level sequencer for the systolic array. It accepts a job, steps the fetcher through
// clear/load/start/wait, captures the result matrix and streams it out one word per transfer.
module sys_array_sequencer #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ARRAY_W     = 5,
  parameter int unsigned ARRAY_L     = 2,
  parameter int unsigned LOAD_CYCLES = 2,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          job_req,
  output logic                                          job_ack,
  output logic                                          arr_reset_n,
  output logic                                          load_params,
  output logic                                          start_comp,
  input  logic                                          arr_ready,
  input  logic [ARRAY_W*ARRAY_W*2*DATA_WIDTH-1:0]       arr_data,
  output logic                                          res_valid,
  input  logic                                          res_ready,
  output logic [2*DATA_WIDTH-1:0]                       res_data,
  output logic [$clog2(ARRAY_W*ARRAY_W)-1:0]            res_index,
  output logic                                          res_last,
  output logic                                          busy,
  output logic                                          timeout_err
);

  localparam int unsigned N   = ARRAY_W * ARRAY_W;
  localparam int unsigned RW  = 2 * DATA_WIDTH;
  localparam int unsigned IW  = $clog2(N);
  localparam int unsigned WCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned LCW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

  localparam logic [IW-1:0]  LastIdx    = IW'(N - 1);
  localparam logic [WCW-1:0] WaitMax    = '1;
  localparam logic [WCW-1:0] TimeoutVal = WCW'(TIMEOUT);
  localparam logic [LCW-1:0] LoadLast   = LCW'(LOAD_CYCLES - 1);

  if (ARRAY_W < 2 || ARRAY_L < 1 || LOAD_CYCLES < 1) begin : g_bad_params
    $error("sys_array_sequencer: need ARRAY_W >= 2, ARRAY_L >= 1, LOAD_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE, ST_CLEAR, ST_LOAD, ST_START, ST_WAIT, ST_CAPTURE, ST_STREAM
  } state_e;

  state_e          state_q;
  logic [LCW-1:0]  load_cnt_q;
  logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [IW-1:0]   res_index_q, res_index_d;
  logic [RW-1:0]   res_data_q;
  logic [RW-1:0]   res_buf_q [N];
  logic            job_ack_q, arr_reset_n_q, load_params_q, start_comp_q;
  logic            res_valid_q, res_last_q, busy_q, timeout_err_q;

  // NOTE: combinational helpers use blocking assignments and a full default, so no latch is inferred.
  always_comb begin
    wait_cnt_d  = (wait_cnt_q == WaitMax) ? wait_cnt_q : wait_cnt_q + WCW'(1);
    res_index_d = res_index_q + IW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      load_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      res_index_q   <= '0;
      res_data_q    <= '0;
      job_ack_q     <= 1'b0;
      arr_reset_n_q <= 1'b0;
      load_params_q <= 1'b0;
      start_comp_q  <= 1'b0;
      res_valid_q   <= 1'b0;
      res_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          arr_reset_n_q <= 1'b1;
          if (job_req) begin
            state_q       <= ST_CLEAR;
            job_ack_q     <= 1'b1;
            arr_reset_n_q <= 1'b0;
            busy_q        <= 1'b1;
            timeout_err_q <= 1'b0;
          end
        end
        ST_CLEAR: begin
          state_q       <= ST_LOAD;
          job_ack_q     <= 1'b0;
          arr_reset_n_q <= 1'b1;
          load_params_q <= 1'b1;
          load_cnt_q    <= '0;
        end
        ST_LOAD: begin
          if (load_cnt_q == LoadLast) begin
            state_q       <= ST_START;
            load_params_q <= 1'b0;
            start_comp_q  <= 1'b1;
          end else begin
            load_cnt_q <= load_cnt_q + LCW'(1);
          end
        end
        ST_START: begin
          state_q      <= ST_WAIT;
          start_comp_q <= 1'b0;
          wait_cnt_q   <= '0;
        end
        ST_WAIT: begin
          wait_cnt_q <= wait_cnt_d;
          // A completion arriving on the expiry cycle still counts as success.
          if (arr_ready) begin
            state_q <= ST_CAPTURE;
          end else if (TIMEOUT != 0 && wait_cnt_d == TimeoutVal) begin
            state_q       <= ST_IDLE;
            timeout_err_q <= 1'b1;
            busy_q        <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          state_q     <= ST_STREAM;
          res_data_q  <= arr_data[RW-1:0];
          res_index_q <= '0;
          res_last_q  <= 1'b0;
          res_valid_q <= 1'b1;
        end
        ST_STREAM: begin
          if (res_ready) begin
            if (res_index_q == LastIdx) begin
              state_q     <= ST_IDLE;
              res_valid_q <= 1'b0;
              res_last_q  <= 1'b0;
              busy_q      <= 1'b0;
            end else begin
              res_index_q <= res_index_d;
              res_data_q  <= res_buf_q[res_index_d];
              res_last_q  <= (res_index_d == LastIdx);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the result buffer is not reset; CAPTURE always overwrites it before any word is read.
  always_ff @(posedge clk) begin
    if (state_q == ST_CAPTURE) begin
      for (int k = 0; k < N; k++) begin
        res_buf_q[k] <= arr_data[k*RW +: RW];
      end
    end
  end

  assign job_ack     = job_ack_q;
  assign arr_reset_n = arr_reset_n_q;
  assign load_params = load_params_q;
  assign start_comp  = start_comp_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_index   = res_index_q;
  assign res_last    = res_last_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule
